// File: rtl/led_pkg.sv
// Shared definitions for the LED-matrix frame buffer path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_pkg;

    // Default geometry: 1024 RGB888 pixels per bank.
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 24;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_SWAP_PEND = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fb_bank_arbiter.sv
// Front/back frame-bank arbiter: display reads first, then back-bank clear, then writer.
// Latency: memory port combinational; display data one cycle after grant.
// Backpressure: wr_ready drops while the display reads, while a clear runs, or in reset.
module fb_bank_arbiter
    import led_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_req,
    input  logic              swap_req,
    input  logic              frame_end,
    output logic              busy,
    output logic              swap_done,
    output logic              front_bank,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_swap_pend;
    logic              r_front_bank;
    logic              r_swap_done;
    logic              r_disp_valid;

    // Grants in priority order; nothing touches the memory while reset is held.
    logic w_disp_gnt;
    logic w_clr_wr;
    logic w_wr_gnt;

    assign w_disp_gnt = disp_req & ~rst;
    assign w_clr_wr   = (r_state == ST_CLEAR) & ~disp_req & ~rst;
    assign w_wr_gnt   = wr_valid & ~disp_req & ~rst & (r_state != ST_CLEAR);

    assign wr_ready   = w_wr_gnt;
    assign busy       = (r_state != ST_IDLE);
    assign swap_done  = r_swap_done;
    assign front_bank = r_front_bank;
    assign disp_valid = r_disp_valid;
    // The memory returns read data in the cycle after the grant, which is
    // exactly the cycle the registered valid is high; zero otherwise.
    assign disp_data  = r_disp_valid ? mem_rdata : '0;

    // Single-port memory mux: display read, else clear write, else writer write.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_disp_gnt) begin
            mem_en   = 1'b1;
            mem_addr = {r_front_bank, disp_addr};
        end else if (w_clr_wr) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {~r_front_bank, r_clr_cnt};
        end else if (w_wr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {~r_front_bank, wr_addr};
            mem_wdata = wr_data;
        end
    end

    // Sequencer: clear walk, pending swap, and bank toggle at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_clr_cnt    <= '0;
            r_swap_pend  <= 1'b0;
            r_front_bank <= 1'b0;
            r_swap_done  <= 1'b0;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= disp_req;
            r_swap_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        // Clear takes precedence; a simultaneous swap waits for it.
                        r_state     <= ST_CLEAR;
                        r_clr_cnt   <= '0;
                        r_swap_pend <= swap_req;
                    end else if (swap_req) begin
                        if (frame_end) begin
                            r_front_bank <= ~r_front_bank;
                            r_swap_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SWAP_PEND;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (swap_req) begin
                        r_swap_pend <= 1'b1;
                    end
                    if (w_clr_wr) begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                        if (&r_clr_cnt) begin
                            r_state     <= (r_swap_pend | swap_req) ? ST_SWAP_PEND : ST_IDLE;
                            r_swap_pend <= 1'b0;
                        end
                    end
                end
                ST_SWAP_PEND: begin
                    if (frame_end) begin
                        r_front_bank <= ~r_front_bank;
                        r_swap_done  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
